// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipeline-stage skid register.
// Holds the skid-buffer state encodings, default payload widths used when
// stages pack their boundary payloads, and a small helper for in_ready.
package pipe_skid_reg_pkg;

  // Default per-stage payload packing widths
  localparam int unsigned DEF_PC_W   = 32;
  localparam int unsigned DEF_CTRL_W = 16;
  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_CNT_W  = 16;

  // Occupancy of the main + skid register pair
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

  // A stage can take a new entry unless both registers are occupied
  function automatic logic state_has_room(input skid_state_e s);
    return s != SKID_FULL;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (count -> 0)
//   inc  - increment request; ignored once the count is all-ones
//   clr  - synchronous clear, wins over inc
//   cnt  - registered count
module sat_counter
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count up, stick at all-ones
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_reg.sv
// Generic pipeline-stage register for one inter-stage boundary.
// A main register drives the outputs; a single skid register absorbs the
// entry that arrives in the cycle downstream stops accepting, so in_ready
// can be a flop with no combinational path from out_ready.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   stall             - global freeze (flush and the bubble counter still act)
//   flush             - drop everything; PC of a valid incoming entry is kept
//   in_valid/in_ready - upstream handshake (in_ready registered)
//   in_pc/ctrl/data   - upstream payload
//   out_valid/ready   - downstream handshake
//   out_pc/ctrl/data  - registered payload; ctrl/data are 0 when invalid
//   bubble_cnt        - saturating count of idle cycles seen by downstream
//   bubble_clr        - synchronous clear of bubble_cnt
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned PC_W   = DEF_PC_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt,
  input  logic              bubble_clr
);

  skid_state_e       r_state, w_state_nxt;
  logic              r_in_ready, r_out_valid;
  logic [PC_W-1:0]   r_pc, w_pc_nxt, r_skid_pc, w_skid_pc_nxt;
  logic [CTRL_W-1:0] r_ctrl, w_ctrl_nxt, r_skid_ctrl, w_skid_ctrl_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt, r_skid_data, w_skid_data_nxt;
  logic              w_accept, w_issue, w_bubble_inc;

  // Handshakes; both already qualified by stall, so stall simply holds state
  assign w_accept     = in_valid & r_in_ready & ~stall;
  assign w_issue      = r_out_valid & out_ready & ~stall;
  assign w_bubble_inc = ~r_out_valid & out_ready & ~stall & ~flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SKID_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next main/skid contents
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_ctrl_nxt      = r_ctrl;
    w_data_nxt      = r_data;
    w_skid_pc_nxt   = r_skid_pc;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;

    if (flush) begin
      // PC survives so exception logic still sees where the flush happened
      w_state_nxt     = SKID_EMPTY;
      w_pc_nxt        = in_valid ? in_pc : r_pc;
      w_ctrl_nxt      = '0;
      w_data_nxt      = '0;
      w_skid_pc_nxt   = '0;
      w_skid_ctrl_nxt = '0;
      w_skid_data_nxt = '0;
    end else begin
      unique case (r_state)
        SKID_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = SKID_ONE;
            w_pc_nxt    = in_pc;
            w_ctrl_nxt  = in_ctrl;
            w_data_nxt  = in_data;
          end
        end
        SKID_ONE: begin
          if (w_accept && w_issue) begin
            w_pc_nxt   = in_pc;
            w_ctrl_nxt = in_ctrl;
            w_data_nxt = in_data;
          end else if (w_accept) begin
            w_state_nxt     = SKID_FULL;
            w_skid_pc_nxt   = in_pc;
            w_skid_ctrl_nxt = in_ctrl;
            w_skid_data_nxt = in_data;
          end else if (w_issue) begin
            // Keep last PC visible, but an empty stage carries a pure bubble
            w_state_nxt = SKID_EMPTY;
            w_ctrl_nxt  = '0;
            w_data_nxt  = '0;
          end
        end
        SKID_FULL: begin
          if (w_issue) begin
            w_state_nxt     = SKID_ONE;
            w_pc_nxt        = r_skid_pc;
            w_ctrl_nxt      = r_skid_ctrl;
            w_data_nxt      = r_skid_data;
            w_skid_pc_nxt   = '0;
            w_skid_ctrl_nxt = '0;
            w_skid_data_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = SKID_EMPTY;
          w_ctrl_nxt  = '0;
          w_data_nxt  = '0;
        end
      endcase
    end
  end

  // Payload and handshake flops; out_valid/in_ready follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_pc        <= '0;
      r_ctrl      <= '0;
      r_data      <= '0;
      r_skid_pc   <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_out_valid <= (w_state_nxt != SKID_EMPTY);
      r_in_ready  <= state_has_room(w_state_nxt);
      r_pc        <= w_pc_nxt;
      r_ctrl      <= w_ctrl_nxt;
      r_data      <= w_data_nxt;
      r_skid_pc   <= w_skid_pc_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

  // Idle-cycle counter for performance monitoring
  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk(clk),
    .rst(rst),
    .inc(w_bubble_inc),
    .clr(bubble_clr),
    .cnt(bubble_cnt)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_pc    = r_pc;
  assign out_ctrl  = r_ctrl;
  assign out_data  = r_data;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: table of per-cycle vectors plus a
// hand-written bubble-counter sequence.
module tb_pipe_skid_reg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst, stall, flush, in_valid, in_ready, out_valid, out_ready, bubble_clr;
  logic [PC_W-1:0]   in_pc, out_pc;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CNT_W-1:0]  bubble_cnt;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ctrl(out_ctrl), .out_data(out_data),
    .bubble_cnt(bubble_cnt), .bubble_clr(bubble_clr)
  );

  typedef struct {
    logic        rst, stall, flush, iv;
    logic [31:0] ipc;
    logic        ordy;
    logic        ov, ir;
    logic [31:0] pc;
    logic        chk_bc;
    logic [3:0]  bc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Payload fields are derived from the PC so order/duplication is visible
  function automatic logic [15:0] ctrl_of(input logic [31:0] pc);
    return pc[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [127:0] data_of(input logic [31:0] pc);
    return {pc, ~pc, pc ^ 32'h1234_5678, pc + 32'd1};
  endfunction

  function automatic void v(input logic r, st, fl, iv, input logic [31:0] ipc,
                            input logic ordy, ov, ir, input logic [31:0] pc,
                            input logic chk_bc, input logic [3:0] bc);
    vec_t t;
    t.rst = r; t.stall = st; t.flush = fl; t.iv = iv; t.ipc = ipc; t.ordy = ordy;
    t.ov = ov; t.ir = ir; t.pc = pc; t.chk_bc = chk_bc; t.bc = bc;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, st, fl, iv, input logic [31:0] ipc,
                       input logic ordy, input logic clr);
    rst = r; stall = st; flush = fl; in_valid = iv; in_pc = ipc;
    in_ctrl = ctrl_of(ipc); in_data = data_of(ipc);
    out_ready = ordy; bubble_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);

    // Reset with a valid entry pending
    v(1,0,0,1,32'h100,1, 0,1,32'h0, 1,4'd0);
    v(1,0,0,1,32'h100,1, 0,1,32'h0, 1,4'd0);
    // Streaming at full rate: each PC visible one cycle after accept
    for (int k = 0; k < 8; k++)
      v(0,0,0,1,32'h100 + 32'(4*k),1, 1,1,32'h100 + 32'(4*k), 0,4'd0);
    v(0,0,0,0,32'h0,1, 0,1,32'h11C, 1,4'd1);
    // Backpressure: fill to FULL, then drain in order
    v(0,0,0,1,32'h200,0, 1,1,32'h200, 0,4'd0);
    v(0,0,0,1,32'h204,0, 1,0,32'h200, 0,4'd0);
    v(0,0,0,1,32'h208,0, 1,0,32'h200, 0,4'd0);
    v(0,0,0,1,32'h208,1, 1,1,32'h204, 0,4'd0);
    v(0,0,0,1,32'h208,1, 1,1,32'h208, 0,4'd0);
    v(0,0,0,0,32'h0,1,   0,1,32'h208, 0,4'd0);
    // Stall while FULL: everything frozen, then drain resumes
    v(0,0,0,1,32'h300,0, 1,1,32'h300, 0,4'd0);
    v(0,0,0,1,32'h304,0, 1,0,32'h300, 0,4'd0);
    for (int k = 0; k < 4; k++)
      v(0,1,0,1,32'h308,1, 1,0,32'h300, 0,4'd0);
    v(0,0,0,0,32'h0,1,   1,1,32'h304, 0,4'd0);
    v(0,0,0,0,32'h0,1,   0,1,32'h304, 0,4'd0);
    // Flush from FULL keeps the incoming PC; skid must not reappear
    v(0,0,0,1,32'h400,0, 1,1,32'h400, 0,4'd0);
    v(0,0,0,1,32'h404,0, 1,0,32'h400, 0,4'd0);
    v(0,0,1,1,32'hBFC00380,0, 0,1,32'hBFC00380, 0,4'd0);
    v(0,0,0,0,32'h0,1,   0,1,32'hBFC00380, 0,4'd0);
    // Flush together with stall
    v(0,0,0,1,32'h500,0, 1,1,32'h500, 0,4'd0);
    v(0,0,0,1,32'h504,0, 1,0,32'h500, 0,4'd0);
    v(0,1,1,1,32'hBFC00380,1, 0,1,32'hBFC00380, 0,4'd0);
    v(0,0,0,0,32'h0,1,   0,1,32'hBFC00380, 0,4'd0);
    // Flush without a valid input holds the old PC
    v(0,0,0,1,32'h600,0, 1,1,32'h600, 0,4'd0);
    v(0,0,1,0,32'h0,0,   0,1,32'h600, 0,4'd0);
    // Reset mid-transfer from FULL loses both entries
    v(0,0,0,1,32'h700,0, 1,1,32'h700, 0,4'd0);
    v(0,0,0,1,32'h704,0, 1,0,32'h700, 0,4'd0);
    v(1,0,0,1,32'h708,1, 0,1,32'h0, 1,4'd0);
    v(0,0,0,0,32'h0,1,   0,1,32'h0, 0,4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].iv,
            vecs[i].ipc, vecs[i].ordy, 1'b0);
      tick();
      check($sformatf("v%0d out_valid", i), 128'(out_valid), 128'(vecs[i].ov));
      check($sformatf("v%0d in_ready", i), 128'(in_ready), 128'(vecs[i].ir));
      check($sformatf("v%0d out_pc", i), 128'(out_pc), 128'(vecs[i].pc));
      check($sformatf("v%0d out_ctrl", i), 128'(out_ctrl),
            vecs[i].ov ? 128'(ctrl_of(vecs[i].pc)) : 128'(0));
      check($sformatf("v%0d out_data", i), out_data,
            vecs[i].ov ? data_of(vecs[i].pc) : 128'(0));
      if (vecs[i].chk_bc)
        check($sformatf("v%0d bubble_cnt", i), 128'(bubble_cnt), 128'(vecs[i].bc));
    end

    // Bubble counter: clear, count idle cycles, saturate at 15
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    check("bc clear", 128'(bubble_cnt), 128'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) tick();
    check("bc reach 15", 128'(bubble_cnt), 128'(15));
    for (int k = 0; k < 5; k++) tick();
    check("bc saturate", 128'(bubble_cnt), 128'(15));
    // Clear wins over a simultaneous increment
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    check("bc clr over inc", 128'(bubble_cnt), 128'(0));
    // Stall and flush suppress counting
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    check("bc stall hold", 128'(bubble_cnt), 128'(0));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check("bc flush hold", 128'(bubble_cnt), 128'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check("bc resume", 128'(bubble_cnt), 128'(1));
    // out_ready low is not a bubble
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("bc no ready", 128'(bubble_cnt), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline-stage register for inter-stage boundaries (IF/ID … MEM/WB) in MangoMIPS32.
- Replaces the fixed stall/flush stage registers with a generic payload register built from a 2-entry skid buffer and valid/ready handshakes.
- Supports global stall, flush with PC preservation, and a saturating bubble counter for performance monitoring.
- One instance per stage boundary; payload layout is packed by the instantiating stage.

Parameters:
- PC_W, 32, width of the PC field; always carried through, including on flush.
- CTRL_W, 16, width of control/write-enable field; zeroed to form a bubble.
- DATA_W, 128, width of the data payload; zeroed on flush.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  global freeze; no state changes while high, except the bubble counter and flush.
- flush  in  1  discard all held and incoming entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry.
- in_pc  in  PC_W  upstream PC.
- in_ctrl  in  CTRL_W  upstream control.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  registered PC.
- out_ctrl  out  CTRL_W  registered control; 0 when out_valid=0.
- out_data  out  DATA_W  registered payload; 0 when out_valid=0.
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1; saturating.
- bubble_clr  in  1  synchronous clear of bubble_cnt.

Behaviour:
- Handshake definitions:
  - Accept = in_valid & in_ready & ~stall.
  - Issue = out_valid & out_ready & ~stall.
- Storage: main register (drives outputs) plus one skid register.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: both valid.
- in_ready is registered: in_ready = (state != FULL). There is no combinational path from out_ready to in_ready.
- Transitions, all gated by ~stall:
  - EMPTY + accept → ONE; main <= input.
  - ONE + accept + issue → ONE; main <= input.
  - ONE + accept, no issue → FULL; skid <= input.
  - ONE + issue, no accept → EMPTY.
  - FULL + issue → ONE; main <= skid.
  - FULL never accepts, because in_ready=0.
- Latency: 1 cycle from accept to out_valid when the stage is EMPTY or issuing.
- Throughput: 1 entry/cycle with out_ready held high.
- Stall=1: state, main, skid and outputs hold. in_ready and out_valid keep their values, but no transfer occurs.
- Flush=1 (priority over stall and handshakes):
  - Next cycle: state=EMPTY, out_valid=0, out_ctrl=0, out_data=0, in_ready=1, skid cleared.
  - out_pc <= in_pc if in_valid, else holds. The PC is retained so exception/EPC logic sees a meaningful PC.
  - The incoming entry is not accepted.
- Reset has priority over flush. On rst=1 at a clock edge:
  - state=EMPTY; out_valid=0; in_ready=1 (EMPTY state); out_pc=0; out_ctrl=0; out_data=0; skid cleared; bubble_cnt=0.
  - Applies mid-transfer: any held entry is lost.
- Bubble counter:
  - Increments when out_valid=0 & out_ready=1 & ~stall & ~flush.
  - Saturates at 2^CNT_W−1; no wrap.
  - bubble_clr has priority over increment.
- Invariants:
  - out_ctrl and out_data are exactly 0 whenever out_valid=0.
  - Entry order is preserved; no entry is ever duplicated or dropped except by flush/rst.

Decomposition:
- Defines.v gains:
  - state encodings SKID_EMPTY=2'b00, SKID_ONE=2'b01, SKID_FULL=2'b10;
  - ZeroWord/ZeroDWord reuse;
  - default widths for per-stage payload packing.
- One sub-module: sat_counter (parametrised width, inc, clr, saturating), used for bubble_cnt.
- Everything else stays in pipe_skid_reg.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, out_pc=0, out_ctrl=0, out_data=0, in_ready=1, bubble_cnt=0.
- Streaming: out_ready=1; 8 entries with PC 0x100, 0x104, …, 0x11C → each out_pc appears exactly 1 cycle after accept, in order, no gaps.
- Backpressure:
  - Drop out_ready for 3 cycles while in_valid=1 → state reaches FULL, in_ready=0 after 2 accepts, no entry lost.
  - Raise out_ready → entries drain in order.
- Stall: assert stall in FULL for 4 cycles with out_ready=1 → outputs frozen, no issue, no accept; release → drain resumes with the same entry.
- Flush:
  - Setup: FULL state, in_valid=1, in_pc=0xBFC00380, flush=1 for one cycle.
  - Required: next cycle out_valid=0, out_ctrl=0, out_data=0, out_pc=0xBFC00380, in_ready=1.
  - Also: flush together with stall=1 gives the same result.
- Counter:
  - Run with CNT_W=4: idle input, out_ready=1 for 20 cycles → bubble_cnt saturates at 15.
  - bubble_clr together with an increment condition → bubble_cnt=0.
